// File: rtl/vga_timing_gen.sv
// VGA/DVI raster timing generator: pixel-clock divider, zero-skew registered syncs,
// a lead-time fetch coordinate pair and a vblank-aligned buffer-swap handshake.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned CW        = 10,
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter bit          H_POL     = 1'b0,
   parameter bit          V_POL     = 1'b0,
   parameter int unsigned LEAD      = 0
) (
   input  logic          clock,
   input  logic          reset,
   output logic          p_tick,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic          vblank,
   output logic          line_start,
   output logic          frame_start,
   output logic [CW-1:0] fetch_x,
   output logic [CW-1:0] fetch_y,
   output logic          fetch_valid,
   input  logic          swap_req,
   output logic          swap_ack,
   output logic          buf_sel
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_DISPLAY);
   localparam logic [CW-1:0] V_ACT    = CW'(V_DISPLAY);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_DISPLAY + H_FRONT);
   localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_DISPLAY + V_FRONT);
   localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC);

   // Fetch starts LEAD pixels past the last pixel of the frame, i.e. (LEAD-1,0).
   localparam logic [CW-1:0] FX_RST = (LEAD == 0) ? H_LAST : CW'(LEAD - 1);
   localparam logic [CW-1:0] FY_RST = (LEAD == 0) ? V_LAST : '0;
   localparam logic          FV_RST = (FX_RST < H_ACT) && (FY_RST < V_ACT);

   typedef enum logic {S_IDLE, S_ACKED} swap_state_e;

   swap_state_e   state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic          p_tick_q, p_tick_d;
   logic [CW-1:0] x_q, x_d, y_q, y_d, fx_q, fx_d, fy_q, fy_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d;
   logic          video_on_q, video_on_d, vblank_q, vblank_d, fetch_valid_q, fetch_valid_d;
   logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic          swap_ack_q, swap_ack_d, buf_sel_q, buf_sel_d;

   function automatic logic [2*CW-1:0] step(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
      logic [CW-1:0] nx, ny;
      nx = cx + CW'(1);
      ny = cy;
      if (cx == H_LAST) begin
         nx = '0;
         ny = (cy == V_LAST) ? '0 : cy + CW'(1);
      end
      return {ny, nx};
   endfunction

   always_comb begin
      div_d         = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      p_tick_d      = (div_q == DIV_LAST);
      x_d           = x_q;
      y_d           = y_q;
      fx_d          = fx_q;
      fy_d          = fy_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      swap_ack_d    = 1'b0;
      buf_sel_d     = buf_sel_q;
      state_d       = state_q;

      if (p_tick_q) begin
         {y_d, x_d}    = step(x_q, y_q);
         {fy_d, fx_d}  = step(fx_q, fy_q);
         line_start_d  = (x_d == '0);
         frame_start_d = (x_d == '0) && (y_d == '0);
      end

      // Decoded from the next coordinates so syncs and flags carry no skew vs x/y.
      hsync_d       = ((x_d >= HS_BEG) && (x_d < HS_END)) ? H_POL : ~H_POL;
      vsync_d       = ((y_d >= VS_BEG) && (y_d < VS_END)) ? V_POL : ~V_POL;
      video_on_d    = (x_d < H_ACT) && (y_d < V_ACT);
      vblank_d      = (y_d >= V_ACT);
      fetch_valid_d = (fx_d < H_ACT) && (fy_d < V_ACT);

      case (state_q)
         S_IDLE: begin
            if (p_tick_q && (x_d == '0) && (y_d == V_ACT) && swap_req) begin
               swap_ack_d = 1'b1;
               buf_sel_d  = ~buf_sel_q;
               state_d    = S_ACKED;
            end
         end
         S_ACKED: if (!swap_req) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         div_q         <= '0;
         p_tick_q      <= 1'b0;
         x_q           <= H_LAST;
         y_q           <= V_LAST;
         fx_q          <= FX_RST;
         fy_q          <= FY_RST;
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         video_on_q    <= 1'b0;
         vblank_q      <= 1'b1;
         fetch_valid_q <= FV_RST;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         swap_ack_q    <= 1'b0;
         buf_sel_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         p_tick_q      <= p_tick_d;
         x_q           <= x_d;
         y_q           <= y_d;
         fx_q          <= fx_d;
         fy_q          <= fy_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         vblank_q      <= vblank_d;
         fetch_valid_q <= fetch_valid_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         swap_ack_q    <= swap_ack_d;
         buf_sel_q     <= buf_sel_d;
      end
   end

   assign p_tick      = p_tick_q;
   assign x           = x_q;
   assign y           = y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign vblank      = vblank_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign fetch_x     = fx_q;
   assign fetch_y     = fy_q;
   assign fetch_valid = fetch_valid_q;
   assign swap_ack    = swap_ack_q;
   assign buf_sel     = buf_sel_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-raster configurations checked every cycle
// against a linear-position model, plus directed literal checks on instance 0.
module tb_vga_timing_gen;

   localparam int CW = 4;
   localparam int HD = 8, HF = 2, HS = 3, HB = 2, HT = 15;
   localparam int VD = 6, VF = 1, VS = 2, VB = 1, VT = 10;
   localparam int FR = HT * VT;
   localparam int NI = 3;
   localparam int CDV [NI] = '{2, 3, 1};
   localparam int LDV [NI] = '{4, 0, 14};
   localparam bit HPV [NI] = '{1'b0, 1'b1, 1'b1};
   localparam bit VPV [NI] = '{1'b0, 1'b1, 1'b0};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic swap_req = 1'b0;
   always #5 clk = ~clk;

   logic          pt [NI], hs [NI], vs [NI], von [NI], vbl [NI], ls [NI], fs [NI];
   logic          fv [NI], ack [NI], bsel [NI];
   logic [CW-1:0] xw [NI], yw [NI], fxw [NI], fyw [NI];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : inst
      localparam int CD = CDV[g];
      localparam int LD = LDV[g];
      localparam bit HP = HPV[g];
      localparam bit VP = VPV[g];

      vga_timing_gen #(
         .CLK_DIV(CD), .CW(CW),
         .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
         .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
         .H_POL(HP), .V_POL(VP), .LEAD(LD)
      ) dut (
         .clock(clk), .reset(rst_n), .p_tick(pt[g]), .x(xw[g]), .y(yw[g]),
         .hsync(hs[g]), .vsync(vs[g]), .video_on(von[g]), .vblank(vbl[g]),
         .line_start(ls[g]), .frame_start(fs[g]), .fetch_x(fxw[g]), .fetch_y(fyw[g]),
         .fetch_valid(fv[g]), .swap_req(swap_req), .swap_ack(ack[g]), .buf_sel(bsel[g])
      );

      // Model: e = clock edges since reset release; ticks elapsed = (e-1)/CD.
      int   e = 0;
      int   st = 0;
      logic ack_m = 1'b0;
      logic buf_m = 1'b0;

      function automatic int pos_of(input int ee);
         int k;
         k = (ee >= 1) ? (ee - 1) / CD : 0;
         return (FR - 1 + k) % FR;
      endfunction

      function automatic bit adv_at(input int ee);
         return (ee >= 2) && ((ee - 1) % CD == 0);
      endfunction

      always @(posedge clk or negedge rst_n) begin : model
         int ne;
         if (!rst_n) begin
            e <= 0; st <= 0; ack_m <= 1'b0; buf_m <= 1'b0;
         end else begin
            ne = e + 1;
            e <= ne;
            ack_m <= 1'b0;
            if (st == 0) begin
               if (adv_at(ne) && pos_of(ne) == VD * HT && swap_req) begin
                  ack_m <= 1'b1;
                  buf_m <= ~buf_m;
                  st    <= 1;
               end
            end else if (!swap_req) st <= 0;
         end
      end

      always @(negedge clk) begin : cmp
         int p, ex, ey, fp, fx, fy;
         bit adv;
         p  = pos_of(e);
         ex = p % HT;
         ey = p / HT;
         fp = (p + LD) % FR;
         fx = fp % HT;
         fy = fp / HT;
         adv = adv_at(e);
         chk($sformatf("i%0d.p_tick", g), pt[g], (e >= 1) && (e % CD == 0));
         chk($sformatf("i%0d.x", g), xw[g], ex);
         chk($sformatf("i%0d.y", g), yw[g], ey);
         chk($sformatf("i%0d.hsync", g), hs[g], (ex >= HD + HF && ex < HD + HF + HS) ? HP : !HP);
         chk($sformatf("i%0d.vsync", g), vs[g], (ey >= VD + VF && ey < VD + VF + VS) ? VP : !VP);
         chk($sformatf("i%0d.video_on", g), von[g], ex < HD && ey < VD);
         chk($sformatf("i%0d.vblank", g), vbl[g], ey >= VD);
         chk($sformatf("i%0d.line_start", g), ls[g], adv && ex == 0);
         chk($sformatf("i%0d.frame_start", g), fs[g], adv && p == 0);
         chk($sformatf("i%0d.fetch_x", g), fxw[g], fx);
         chk($sformatf("i%0d.fetch_y", g), fyw[g], fy);
         chk($sformatf("i%0d.fetch_valid", g), fv[g], fx < HD && fy < VD);
         chk($sformatf("i%0d.swap_ack", g), ack[g], ack_m);
         chk($sformatf("i%0d.buf_sel", g), bsel[g], buf_m);
      end
   end

   task automatic wait_pos(input int i, input int xx, input int yy);
      int n = 0;
      while (!(xw[i] == CW'(xx) && yw[i] == CW'(yy)) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk($sformatf("timeout_pos_%0d_%0d", xx, yy), 0, 1);
   endtask

   task automatic wait_ack(input int i);
      int n = 0;
      while (!ack[i] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk("timeout_ack", 0, 1);
   endtask

   task automatic count_acks(input int i, input int cycles, output int cnt);
      cnt = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (ack[i]) cnt++;
      end
   endtask

   initial begin : stim
      int n;
      repeat (3) @(negedge clk);
      chk("rst_x", xw[0], 14);
      chk("rst_y", yw[0], 9);
      chk("rst_fetch_x", fxw[0], 3);
      chk("rst_fetch_y", fyw[0], 0);
      chk("rst_hsync", hs[0], 1);
      chk("rst_vblank", vbl[0], 1);
      chk("rst_fetch_x_lead14", fxw[2], 13);

      rst_n = 1'b1;
      @(negedge clk); chk("tick_edge1", pt[0], 0);
      @(negedge clk); chk("tick_edge2", pt[0], 1);
      @(negedge clk);
      chk("first_x", xw[0], 0);
      chk("first_y", yw[0], 0);
      chk("first_frame_start", fs[0], 1);
      chk("first_fetch_x", fxw[0], 4);

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fs[0] && n < 400);
      chk("frame_clocks", n, 300);

      wait_pos(0, 11, 3);
      chk("lead_wrap_fx", fxw[0], 0);
      chk("lead_wrap_fy", fyw[0], 4);
      wait_pos(0, 11, 9);
      chk("lead_valid_early", fv[0], 1);
      chk("lead_video_off", von[0], 0);
      wait_pos(0, 14, 9);
      chk("lead_frame_fx", fxw[0], 3);
      chk("lead_frame_fy", fyw[0], 0);
      wait_pos(0, 9, 0);
      chk("hsync_before", hs[0], 1);
      wait_pos(0, 10, 0);
      chk("hsync_first", hs[0], 0);
      wait_pos(1, 10, 0);
      chk("hsync_inverted", hs[1], 1);

      wait_pos(0, 0, 2);
      swap_req = 1'b1;
      wait_ack(0);
      chk("ack_x", xw[0], 0);
      chk("ack_y", yw[0], 6);
      chk("ack_buf", bsel[0], 1);
      count_acks(0, 400, n);
      chk("held_no_reack", n, 0);

      swap_req = 1'b0;
      repeat (2) @(negedge clk);
      swap_req = 1'b1;
      wait_ack(0);
      chk("reack_buf", bsel[0], 0);

      swap_req = 1'b0;
      @(negedge clk);
      wait_pos(0, 0, 2);
      swap_req = 1'b1;
      wait_pos(0, 5, 3);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_x", xw[0], 14);
      chk("mid_rst_y", yw[0], 9);
      chk("mid_rst_p_tick", pt[0], 0);
      chk("mid_rst_video_on", von[0], 0);
      chk("mid_rst_fetch_x", fxw[0], 3);
      swap_req = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_x", xw[0], 0);
      chk("post_rst_y", yw[0], 0);
      chk("post_rst_frame_start", fs[0], 1);
      count_acks(0, 350, n);
      chk("dropped_req_no_ack", n, 0);
      chk("dropped_req_buf", bsel[0], 0);

      swap_req = 1'b1;
      wait_ack(0);
      chk("post_rst_ack_buf", bsel[0], 1);
      swap_req = 1'b0;
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor of the fixed 640x480 sync counter.
- Generates VGA/DVI raster timing from one system clock using a programmable pixel-clock divider, with configurable porches and sync polarities.
- Adds a lead-time fetch coordinate pair so frame-buffer read latency can be hidden.
- Adds a vblank-aligned buffer-swap handshake. Sits between the GPU frame buffer and the VGA output pins.

Parameters:
- CLK_DIV, 2: system clocks per pixel (>=1).
- CW, 10: counter/coordinate width. Must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL.
- H_DISPLAY, 640: active pixels per line.
- H_FRONT, 16: horizontal front porch.
- H_SYNC, 96: hsync width.
- H_BACK, 48: horizontal back porch (>=1).
- V_DISPLAY, 480: active lines.
- V_FRONT, 10: vertical front porch.
- V_SYNC, 2: vsync width.
- V_BACK, 33: vertical back porch (>=1).
- H_POL, 0: hsync active level.
- V_POL, 0: vsync active level.
- LEAD, 0: fetch lead in pixels (0..H_TOTAL-1).

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous active-low reset.
- p_tick, out, 1: one-clock pulse, one per pixel.
- x, out, CW: current column.
- y, out, CW: current line.
- hsync, out, 1: horizontal sync at H_POL level.
- vsync, out, 1: vertical sync at V_POL level.
- video_on, out, 1: (x,y) is in the active area.
- vblank, out, 1: y >= V_DISPLAY.
- line_start, out, 1: one-clock pulse when x becomes 0.
- frame_start, out, 1: one-clock pulse when (x,y) becomes (0,0).
- fetch_x, out, CW: column LEAD pixels ahead of x.
- fetch_y, out, CW: line LEAD pixels ahead of y.
- fetch_valid, out, 1: (fetch_x,fetch_y) is in the active area.
- swap_req, in, 1: level request to swap buffers; held until ack.
- swap_ack, out, 1: one-clock acknowledge.
- buf_sel, out, 1: displayed buffer index.

Behaviour:
- Derived: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL analogous.
- Line order: display, front porch, sync, back porch. Same order vertically.
- Divider: div counts 0..CLK_DIV-1 and wraps. p_tick is registered and high in the clock after div==CLK_DIV-1. With CLK_DIV=1, p_tick is constantly high after reset.
- Raster advance: on every clock edge where p_tick is high, x increments. At x==H_TOTAL-1, x wraps to 0 and y increments. At y==V_TOTAL-1, y wraps to 0.
- Registered outputs: hsync, vsync, video_on, vblank, fetch_* and fetch_valid are registered. They update on the same edge as x/y and always describe the new (x,y), giving zero skew.
  - hsync active when H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC; vsync analogous on y.
- Pulses: line_start and frame_start are high for exactly the one clock following the advancing edge that produced x==0 or (0,0) respectively.
- Fetch counter: a second raster counter advancing on the same edges, positioned LEAD pixels ahead in linear (row-major) order, wrapping across lines and frames. With LEAD=0, fetch equals x/y.
- Reset values (asynchronous):
  - div=0, p_tick=0.
  - x=H_TOTAL-1, y=V_TOTAL-1.
  - hsync=~H_POL, vsync=~V_POL, video_on=0, vblank=1.
  - line_start=0, frame_start=0, swap_ack=0, buf_sel=0.
  - fetch position = linear(H_TOTAL-1,V_TOTAL-1)+LEAD mod frame, i.e. (LEAD-1,0) when LEAD>=1; fetch_valid matches that position.
  - Consequence: the first advancing edge after reset release lands on (0,0) with frame_start.
- Swap FSM, states IDLE and ACKED:
  - IDLE: on the advancing edge entering (0,V_DISPLAY) with swap_req=1, pulse swap_ack for one clock, toggle buf_sel, go to ACKED.
  - ACKED: return to IDLE when swap_req=0.
  - A request raised mid-frame waits for the next vblank entry. A request held across multiple frames gets exactly one ack.
  - A request falling and rising again before vblank entry is acked at that entry.
- Reset asserted mid-frame immediately forces all reset values. Any pending request is dropped; the requester must re-assert after reset.
- Widths: all comparisons are unsigned at CW bits. Parameters violating constraints are unsupported.

Test Plan:
- Defaults, reset released → first p_tick 2 clocks later; x=0,y=0 with frame_start; p_tick period exactly 2 clocks; frame = 800x525 ticks = 840000 clocks.
- Defaults → hsync low exactly for x=656..751; vsync low for y=490..491; video_on high for x<640 and y<480; line_start 525 times per frame.
- H_POL=1, V_POL=1, CLK_DIV=3 → sync levels inverted; p_tick period 3; coordinates identical per tick.
- LEAD=4 → fetch_x=4 when x=0; at x=796,y=10, fetch=(0,11); at x=799,y=524, fetch=(3,0); fetch_valid leads video_on rise by 4 ticks.
- swap_req raised at y=100 and held → one swap_ack on entering (0,480); buf_sel 0→1; no second ack at next frame until req drops and rises again.
- Assert reset at x=300,y=200 with swap_req pending → asynchronous return to reset values within the same clock; after release, no ack unless req re-asserted; first tick at (0,0).
